// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor blocks: FSM state
// encoding, default geometry and saturating counter arithmetic.
package bp_pkg;

    localparam int DEF_XLEN = 32;
    localparam int DEF_SETS = 4;
    localparam int IDX_W    = $clog2(DEF_SETS);
    localparam int TAG_W    = DEF_XLEN - 2 - IDX_W;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } fsm_e;

    // Increment v, holding at the all-ones value of a w-bit field.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] max_v;
        max_v = (32'd1 << w) - 32'd1;
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

    // Decrement v, holding at zero.
    function automatic logic [31:0] sat_dec(input logic [31:0] v);
        return (v == 32'd0) ? 32'd0 : v - 32'd1;
    endfunction

    // Weakly-taken / weakly-not-taken starting point for a w-bit counter.
    function automatic logic [31:0] ctr_init(input logic taken, input int w);
        logic [31:0] half;
        half = 32'd1 << (w - 1);
        return taken ? half : half - 32'd1;
    endfunction

endpackage

// File: rtl/btb_victim_sel.sv
// Replacement choice for one set: lowest-index invalid way, otherwise the
// oldest way with ties resolved toward the lowest index.
module btb_victim_sel #(
    parameter int WAYS     = 2,
    parameter int AGE_BITS = 4,
    parameter int WW       = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic [WAYS-1:0]          valid,
    input  logic [WAYS*AGE_BITS-1:0] ages,
    output logic [WW-1:0]            victim
);

    logic                found;
    logic [AGE_BITS-1:0] best;

    // Scan ways in ascending order; strict compare keeps the lowest index on ties.
    always_comb begin
        victim = '0;
        found  = 1'b0;
        best   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!valid[w] && !found) begin
                victim = WW'(w);
                found  = 1'b1;
            end
        end
        if (!found) begin
            best = ages[0 +: AGE_BITS];
            for (int w = 1; w < WAYS; w++) begin
                if (ages[w*AGE_BITS +: AGE_BITS] > best) begin
                    best   = ages[w*AGE_BITS +: AGE_BITS];
                    victim = WW'(w);
                end
            end
        end
    end

endmodule

// File: rtl/btb_sa.sv
// Set-associative branch target buffer: combinational lookup for fetch,
// one resolved-branch update per cycle from EX, age-based replacement and
// a set-by-set flush sequencer.
module btb_sa
    import bp_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int SETS     = 4,
    parameter int WAYS     = 2,
    parameter int CTR_BITS = 2,
    parameter int AGE_BITS = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    output logic            busy_o,
    input  logic [XLEN-1:0] lk_pc,
    output logic            lk_hit,
    output logic            lk_taken,
    output logic [XLEN-1:0] lk_target,
    input  logic            up_valid,
    input  logic [XLEN-1:0] up_pc,
    input  logic            up_taken,
    input  logic [XLEN-1:0] up_target
);

    localparam int IW = $clog2(SETS);
    localparam int TW = XLEN - 2 - IW;
    localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic                valid  [SETS][WAYS];
    logic [TW-1:0]       tag    [SETS][WAYS];
    logic [XLEN-1:0]     target [SETS][WAYS];
    logic [CTR_BITS-1:0] ctr    [SETS][WAYS];
    logic [AGE_BITS-1:0] age    [SETS][WAYS];
    logic [AGE_BITS-1:0] age_inc[SETS][WAYS];

    fsm_e          state;
    logic [IW-1:0] fk;
    logic          busy;

    logic [IW-1:0]   lidx, uidx;
    logic [TW-1:0]   ltag, utag;
    logic [WAYS-1:0] lhit_way;
    logic            uhit;
    logic [WW-1:0]   uhit_idx, victim, uway;
    logic            upd_en;
    logic [WAYS-1:0] vvalid;
    logic [WAYS*AGE_BITS-1:0] vages;
    logic [CTR_BITS-1:0] ctr_new;
    logic [31:0]     c_tmp, a_tmp;

    assign busy   = (state == FLUSH);
    assign busy_o = busy;
    assign lidx   = lk_pc[2 +: IW];
    assign ltag   = lk_pc[XLEN-1 -: TW];
    assign uidx   = up_pc[2 +: IW];
    assign utag   = up_pc[XLEN-1 -: TW];
    // A flush request in the same cycle takes priority over the update.
    assign upd_en = up_valid && !busy && !flush_i;
    assign uway   = uhit ? uhit_idx : victim;

    // Fetch-side lookup; all outputs forced to zero while flushing.
    always_comb begin
        lhit_way  = '0;
        lk_hit    = 1'b0;
        lk_taken  = 1'b0;
        lk_target = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!busy && valid[lidx][w] && tag[lidx][w] == ltag) begin
                lhit_way[w] = 1'b1;
                lk_hit      = 1'b1;
                lk_taken    = ctr[lidx][w][CTR_BITS-1];
                lk_target   = target[lidx][w];
            end
        end
    end

    // Update-side tag match and replacement inputs for the indexed set.
    always_comb begin
        uhit     = 1'b0;
        uhit_idx = '0;
        vvalid   = '0;
        vages    = '0;
        for (int w = 0; w < WAYS; w++) begin
            vvalid[w] = valid[uidx][w];
            vages[w*AGE_BITS +: AGE_BITS] = age[uidx][w];
            if (valid[uidx][w] && tag[uidx][w] == utag) begin
                uhit     = 1'b1;
                uhit_idx = WW'(w);
            end
        end
    end

    btb_victim_sel #(
        .WAYS     (WAYS),
        .AGE_BITS (AGE_BITS),
        .WW       (WW)
    ) u_victim (
        .valid  (vvalid),
        .ages   (vages),
        .victim (victim)
    );

    // Next counter value for the written entry: train on hit, seed on allocate.
    always_comb begin
        if (!uhit)
            c_tmp = ctr_init(up_taken, CTR_BITS);
        else if (up_taken)
            c_tmp = sat_inc(32'(ctr[uidx][uway]), CTR_BITS);
        else
            c_tmp = sat_dec(32'(ctr[uidx][uway]));
        ctr_new = c_tmp[CTR_BITS-1:0];
    end

    // Saturating age increment for every entry.
    always_comb begin
        a_tmp = '0;
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                a_tmp         = sat_inc(32'(age[s][w]), AGE_BITS);
                age_inc[s][w] = a_tmp[AGE_BITS-1:0];
            end
        end
    end

    // Flush sequencer: walks fk over all sets; a new request restarts at set 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            fk    <= '0;
        end else if (flush_i) begin
            state <= FLUSH;
            fk    <= '0;
        end else if (state == FLUSH) begin
            if (fk == IW'(SETS - 1))
                state <= IDLE;
            fk <= fk + 1'b1;
        end
    end

    // Entry array: flush clearing, update/allocate, and per-entry aging.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid[s][w]  <= 1'b0;
                    tag[s][w]    <= '0;
                    target[s][w] <= '0;
                    ctr[s][w]    <= '0;
                    age[s][w]    <= '0;
                end
            end
        end else begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (busy && fk == IW'(s)) begin
                        valid[s][w] <= 1'b0;
                        age[s][w]   <= '0;
                    end else if (upd_en && uidx == IW'(s) && uway == WW'(w)) begin
                        ctr[s][w] <= ctr_new;
                        age[s][w] <= '0;
                        if (!uhit) begin
                            valid[s][w]  <= 1'b1;
                            tag[s][w]    <= utag;
                            target[s][w] <= up_target;
                        end else if (up_taken) begin
                            target[s][w] <= up_target;
                        end
                    end else if (valid[s][w]) begin
                        if (lhit_way[w] && lidx == IW'(s))
                            age[s][w] <= '0;
                        else
                            age[s][w] <= age_inc[s][w];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_btb_sa.sv
// Scoreboard bench for btb_sa: a driver issues directed and random cycles,
// pushing the reference model's expected outputs into a queue; a monitor
// pops and compares on the falling edge.
module tb_btb_sa;

    logic        clk = 1'b0;
    logic        rst, flush_i, busy_o;
    logic [31:0] lk_pc, up_pc, up_target, lk_target;
    logic        lk_hit, lk_taken, up_valid, up_taken;

    always #5 clk = ~clk;

    btb_sa #(
        .XLEN(32), .SETS(4), .WAYS(2), .CTR_BITS(2), .AGE_BITS(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (flush_i),
        .busy_o    (busy_o),
        .lk_pc     (lk_pc),
        .lk_hit    (lk_hit),
        .lk_taken  (lk_taken),
        .lk_target (lk_target),
        .up_valid  (up_valid),
        .up_pc     (up_pc),
        .up_taken  (up_taken),
        .up_target (up_target)
    );

    typedef struct {
        bit          hit;
        bit          taken;
        logic [31:0] tgt;
        bit          busy;
        int          id;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc_id = 0;

    // Reference model: 4 sets x 2 ways, values kept as plain integers.
    bit          mv   [4][2];
    logic [27:0] mtag [4][2];
    logic [31:0] mtgt [4][2];
    int          mctr [4][2];
    int          mage [4][2];
    int          mbusy_left = 0;
    int          mfk = 0;

    function automatic int set_of(input logic [31:0] pc);
        return int'(pc[3:2]);
    endfunction

    function automatic logic [27:0] tag_of(input logic [31:0] pc);
        return pc[31:4];
    endfunction

    function automatic int find_way(input logic [31:0] pc);
        int s;
        s = set_of(pc);
        for (int w = 0; w < 2; w++)
            if (mv[s][w] && mtag[s][w] == tag_of(pc)) return w;
        return -1;
    endfunction

    task automatic model_lookup(input logic [31:0] pc, output exp_t e);
        int w;
        e.busy  = (mbusy_left > 0);
        e.hit   = 1'b0;
        e.taken = 1'b0;
        e.tgt   = '0;
        e.id    = cyc_id;
        w = find_way(pc);
        if (!e.busy && w >= 0) begin
            e.hit   = 1'b1;
            e.taken = (mctr[set_of(pc)][w] >= 2);
            e.tgt   = mtgt[set_of(pc)][w];
        end
    endtask

    task automatic model_step(input bit r, input bit fl, input logic [31:0] pc,
                              input bit uv, input logic [31:0] upc,
                              input bit ut, input logic [31:0] utgt);
        int  ls, li, us, uw, best;
        bit  busy, uhit;
        if (r) begin
            for (int s = 0; s < 4; s++)
                for (int w = 0; w < 2; w++) begin
                    mv[s][w] = 0; mtag[s][w] = '0; mtgt[s][w] = '0;
                    mctr[s][w] = 0; mage[s][w] = 0;
                end
            mbusy_left = 0;
            mfk = 0;
            return;
        end
        busy = (mbusy_left > 0);
        ls = set_of(pc);
        li = busy ? -1 : find_way(pc);
        us = set_of(upc);
        uw = -1;
        uhit = 0;
        if (uv && !busy && !fl) begin
            uw = find_way(upc);
            uhit = (uw >= 0);
            if (!uhit) begin
                for (int w = 1; w >= 0; w--)
                    if (!mv[us][w]) uw = w;
                if (uw < 0) begin
                    uw = 0;
                    best = mage[us][0];
                    if (mage[us][1] > best) uw = 1;
                end
            end
        end
        for (int s = 0; s < 4; s++)
            for (int w = 0; w < 2; w++)
                if (mv[s][w]) begin
                    if ((s == ls && w == li) || (s == us && w == uw)) mage[s][w] = 0;
                    else if (mage[s][w] < 15) mage[s][w]++;
                end
        if (busy)
            for (int w = 0; w < 2; w++) begin
                mv[mfk][w] = 0;
                mage[mfk][w] = 0;
            end
        if (uw >= 0) begin
            mage[us][uw] = 0;
            if (uhit) begin
                if (ut) begin
                    if (mctr[us][uw] < 3) mctr[us][uw]++;
                    mtgt[us][uw] = utgt;
                end else if (mctr[us][uw] > 0) begin
                    mctr[us][uw]--;
                end
            end else begin
                mv[us][uw]   = 1;
                mtag[us][uw] = tag_of(upc);
                mtgt[us][uw] = utgt;
                mctr[us][uw] = ut ? 2 : 1;
            end
        end
        if (fl) begin
            mbusy_left = 4;
            mfk = 0;
        end else if (busy) begin
            mbusy_left--;
            mfk++;
        end
    endtask

    // One clock cycle of stimulus; expected outputs are queued before the edge.
    task automatic cyc(input logic [31:0] pc, input bit uv = 0,
                       input logic [31:0] upc = 0, input bit ut = 0,
                       input logic [31:0] utgt = 0, input bit fl = 0,
                       input bit r = 0, input bit chk = 1);
        exp_t e;
        rst = r; flush_i = fl; lk_pc = pc;
        up_valid = uv; up_pc = upc; up_taken = ut; up_target = utgt;
        if (chk) begin
            model_lookup(pc, e);
            q.push_back(e);
        end
        model_step(r, fl, pc, uv, upc, ut, utgt);
        @(posedge clk);
        #1;
        cyc_id++;
    endtask

    function automatic logic [31:0] rand_pc();
        return (32'($urandom_range(0, 7)) << 4) | (32'($urandom_range(0, 3)) << 2)
               | 32'($urandom_range(0, 3));
    endfunction

    // Monitor: the DUT presents a lookup result every cycle; compare on negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (lk_hit !== e.hit || lk_taken !== e.taken ||
                    lk_target !== e.tgt || busy_o !== e.busy) begin
                    errors++;
                    $display("FAIL lookup cycle %0d: got hit=%b taken=%b tgt=%h busy=%b, want hit=%b taken=%b tgt=%h busy=%b",
                             e.id, lk_hit, lk_taken, lk_target, busy_o,
                             e.hit, e.taken, e.tgt, e.busy);
                end
            end
        end
    end

    initial begin
        int wait_cyc;
        @(posedge clk);
        #1;
        cyc(32'h0, .r(1), .chk(0));
        cyc(32'h0, .r(1), .chk(0));

        // Reset state, then train and saturate one entry.
        cyc(32'h100);
        cyc(32'h100, 1, 32'h100, 1, 32'h200);
        cyc(32'h100);
        cyc(32'h100, 1, 32'h100, 0, 32'h300);
        cyc(32'h100, 1, 32'h100, 0, 32'h300);
        cyc(32'h100, 1, 32'h100, 0, 32'h300);
        cyc(32'h100);

        // Conflict eviction in set 0.
        cyc(32'h0, .r(1));
        cyc(32'h0, 1, 32'h100, 1, 32'h1000);
        cyc(32'h0, 1, 32'h110, 1, 32'h1100);
        for (int i = 0; i < 5; i++) cyc(32'h100);
        cyc(32'h0, 1, 32'h120, 1, 32'h1200);
        cyc(32'h110);
        cyc(32'h100);
        cyc(32'h120);

        // Same-cycle lookup and allocate of a new entry.
        cyc(32'h140, 1, 32'h140, 1, 32'h1400);
        cyc(32'h140);

        // Flush with a dropped update during busy, then everything misses.
        cyc(32'h100, .fl(1));
        cyc(32'h120, 1, 32'h180, 1, 32'h1800);
        for (int i = 0; i < 3; i++) cyc(32'h140);
        cyc(32'h180);
        cyc(32'h100);
        cyc(32'h120);

        // Flush restart on the second busy cycle, and reset during a flush.
        cyc(32'h0, 1, 32'h104, 1, 32'h2000);
        cyc(32'h104, .fl(1));
        cyc(32'h104);
        cyc(32'h104, .fl(1));
        for (int i = 0; i < 5; i++) cyc(32'h104);
        cyc(32'h0, .fl(1));
        cyc(32'h0);
        cyc(32'h0, .r(1));
        cyc(32'h0);

        // Same-cycle flush and update: the update is dropped.
        cyc(32'h0, 1, 32'h108, 1, 32'h3000, 1);
        for (int i = 0; i < 5; i++) cyc(32'h108);

        // Random traffic.
        for (int i = 0; i < 2500; i++) begin
            cyc(rand_pc(), $urandom_range(0, 1) == 1, rand_pc(),
                $urandom_range(0, 1) == 1, $urandom(),
                $urandom_range(0, 59) == 0, $urandom_range(0, 399) == 0);
        end
        rst = 0; flush_i = 0; up_valid = 0;

        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
